memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: byte-lane data memory, MEM/WB pipeline register and load extraction.
// Build option MEM_MISALIGN_TRAP_EN enables alignment checking with a sticky MisalignErr flag.
module memory_stage #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallM,
   input  logic        FlushM,
   input  logic [4:0]  RdE,
   input  logic        RegWriteEnE,
   input  logic        MemtoRegE,
   input  logic        JALE,
   input  logic        MemReadE,
   input  logic        MemWriteE,
   input  logic [2:0]  Funct3E,
   input  logic [31:0] PCPlus4E,
   input  logic [31:0] ALU_ResultE,
   input  logic [31:0] WriteDataE,
   output logic [4:0]  RDM,
   output logic        RegWriteEnM,
   output logic        MemtoRegM,
   output logic        JALM,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic        MisalignErr
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          capture;
   logic          misalign;
   logic          wr_en;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic          rd_valid;
   logic [31:0]   rd_word;
   logic [1:0]    rd_off;
   logic [2:0]    rd_f3;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;

   assign idx     = ALU_ResultE[AW+1:2];
   assign off     = ALU_ResultE[1:0];
   assign capture = ~rst & ~StallM & ~FlushM;

`ifdef MEM_MISALIGN_TRAP_EN
   logic half_mis;
   logic word_mis;
   assign half_mis = off[0];
   assign word_mis = (off != 2'b00);
   assign misalign = (MemReadE  & (((Funct3E == 3'b001) | (Funct3E == 3'b101)) & half_mis))
                   | (MemWriteE & (Funct3E == 3'b001) & half_mis)
                   | ((MemReadE | MemWriteE) & (Funct3E == 3'b010) & word_mis);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         MisalignErr <= 1'b0;
      else if (capture && misalign)
         MisalignErr <= 1'b1;
   end
`else
   assign misalign    = 1'b0;
   assign MisalignErr = 1'b0;
`endif

   // Halfwords select by addr[1] only and words ignore addr[1:0], so unaligned
   // accesses truncate naturally when the trap is not built in.
   always_comb begin
      be    = 4'b0000;
      wlane = WriteDataE;
      case (Funct3E)
         3'b000: begin
            be    = 4'b0001 << off;
            wlane = {4{WriteDataE[7:0]}};
         end
         3'b001: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wlane = {2{WriteDataE[15:0]}};
         end
         3'b010: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign wr_en = capture & MemWriteE & ~misalign;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
   end

   // The read samples the pre-edge word, giving read-before-write when a load and store coincide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || FlushM) begin
         RDM         <= '0;
         RegWriteEnM <= 1'b0;
         MemtoRegM   <= 1'b0;
         JALM        <= 1'b0;
         PCPlus4W    <= '0;
         ALU_ResultW <= '0;
         rd_valid    <= 1'b0;
         rd_word     <= '0;
         rd_off      <= '0;
         rd_f3       <= '0;
      end else if (!StallM) begin
         RDM         <= RdE;
         RegWriteEnM <= RegWriteEnE & ~misalign;
         MemtoRegM   <= MemtoRegE;
         JALM        <= JALE;
         PCPlus4W    <= PCPlus4E;
         ALU_ResultW <= ALU_ResultE;
         rd_valid    <= MemReadE;
         rd_word     <= mem[idx];
         rd_off      <= off;
         rd_f3       <= Funct3E;
      end
   end

   assign byte_sel = rd_word[{rd_off, 3'b000} +: 8];
   assign half_sel = rd_off[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      ReadDataW = '0;
      if (rd_valid) begin
         case (rd_f3)
            3'b000:  ReadDataW = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ReadDataW = {{16{half_sel[15]}}, half_sel};
            3'b010:  ReadDataW = rd_word;
            3'b100:  ReadDataW = {24'd0, byte_sel};
            3'b101:  ReadDataW = {16'd0, half_sel};
            default: ReadDataW = '0;
         endcase
      end
   end
endmodule
